// File: rtl/note_recorder.sv
// -----------------------------------------------------------------------------
// note_recorder
//
// Records a short melody typed on four one-hot player keys. The raw keys are
// synchronised and debounced. A debounced 0000 -> nonzero transition, seen while
// armed, starts a note. The note is committed when the keys are released again.
// Multi-key presses (chords) are rejected and raise a sticky error flag.
//
// Ports
//   clk           in   system clock, rising edge
//   resetn        in   asynchronous active-low reset
//   start_record  in   one-cycle pulse, begins (or restarts) a recording
//   note_inputs   in   [3:0] raw asynchronous keys, 1 = pressed
//   max_length    in   [3:0] requested note count, 0 or >4 means 4
//   level_data    out  [15:0] recorded notes, first note in [15:12]
//   level_length  out  [3:0] notes stored so far
//   recording     out  high while a recording is in progress
//   done_record   out  one-cycle pulse when a recording completes
//   chord_error   out  sticky, set when a multi-key press is rejected
// -----------------------------------------------------------------------------
module note_recorder #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int IDLE_TIMEOUT    = 64
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start_record,
  input  logic [3:0]  note_inputs,
  input  logic [3:0]  max_length,
  output logic [15:0] level_data,
  output logic [3:0]  level_length,
  output logic        recording,
  output logic        done_record,
  output logic        chord_error
);

  localparam int DB_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TO_W = (IDLE_TIMEOUT < 2) ? 1 : $clog2(IDLE_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_PRESSED,
    S_STORE,
    S_DONE
  } state_e;

  // ---------------------------------------------------------------------------
  // Synchroniser and debouncer
  // ---------------------------------------------------------------------------
  logic [3:0]      sync1_q, sync2_q;
  logic [3:0]      db_q, db_d;       // debounced keys
  logic [3:0]      track_q, track_d; // synced value currently being qualified
  logic [DB_W-1:0] cnt_q, cnt_d;     // consecutive samples of track_q seen

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    db_d    = db_q;
    track_d = track_q;
    cnt_d   = cnt_q;
    if (sync2_q == db_q) begin
      // Back at the accepted value: abandon any candidate change.
      track_d = db_q;
      cnt_d   = '0;
    end else if (sync2_q != track_q) begin
      // New candidate value; this sample is its first stable cycle.
      track_d = sync2_q;
      if (DEBOUNCE_CYCLES <= 1) begin
        db_d  = sync2_q;
        cnt_d = '0;
      end else begin
        cnt_d = DB_W'(1);
      end
    end else if (cnt_q >= DB_W'(DEBOUNCE_CYCLES - 1)) begin
      db_d  = sync2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + DB_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= '0;
      sync2_q <= '0;
      db_q    <= '0;
      track_q <= '0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= note_inputs;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      track_q <= track_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Recording FSM
  // ---------------------------------------------------------------------------
  state_e          state_q;
  logic [15:0]     data_q;
  logic [3:0]      len_q;
  logic [3:0]      max_len_q;
  logic [3:0]      note_q;
  logic            note_ok_q;
  logic [TO_W-1:0] timer_q;
  logic            rec_q;
  logic            done_q;
  logic            chord_q;

  logic [3:0] max_len_clamped;
  logic [3:0] store_len;
  logic       press_det;
  logic       release_det;

  function automatic logic is_one_hot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  assign max_len_clamped = ((max_length == 4'd0) || (max_length > 4'd4)) ? 4'd4 : max_length;
  // Length after the STORE edge; a rejected chord leaves it unchanged.
  assign store_len       = len_q + {3'd0, note_ok_q};
  // The FSM reacts on the very edge the debounced value changes, so a press or
  // release is acted on one cycle earlier than waiting for db_q to settle.
  assign press_det       = (db_q == 4'd0) && (db_d != 4'd0);
  assign release_det     = (db_d == 4'd0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      data_q    <= '0;
      len_q     <= '0;
      max_len_q <= '0;
      note_q    <= '0;
      note_ok_q <= 1'b0;
      timer_q   <= '0;
      rec_q     <= 1'b0;
      done_q    <= 1'b0;
      chord_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_record) begin
        // Start or restart: any partial recording is discarded silently.
        state_q   <= S_ARMED;
        data_q    <= '0;
        len_q     <= '0;
        max_len_q <= max_len_clamped;
        note_q    <= '0;
        note_ok_q <= 1'b0;
        timer_q   <= '0;
        rec_q     <= 1'b1;
        chord_q   <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: ;
          S_ARMED: begin
            if (press_det) begin
              note_q    <= db_d;
              note_ok_q <= is_one_hot(db_d);
              state_q   <= S_PRESSED;
            end else if (len_q != 4'd0) begin
              if (timer_q >= TO_W'(IDLE_TIMEOUT - 1)) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
                rec_q   <= 1'b0;
              end else begin
                timer_q <= timer_q + TO_W'(1);
              end
            end
          end
          S_PRESSED: begin
            if (release_det) begin
              state_q <= S_STORE;
            end else if (!is_one_hot(db_d)) begin
              note_ok_q <= 1'b0;
            end
          end
          S_STORE: begin
            if (note_ok_q) begin
              case (len_q)
                4'd0:    data_q[15:12] <= note_q;
                4'd1:    data_q[11:8]  <= note_q;
                4'd2:    data_q[7:4]   <= note_q;
                4'd3:    data_q[3:0]   <= note_q;
                default: ;
              endcase
              if (len_q < 4'd4) begin
                len_q <= store_len;
              end
            end else begin
              chord_q <= 1'b1;
            end
            if (store_len == max_len_q) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              rec_q   <= 1'b0;
            end else begin
              state_q <= S_ARMED;
              timer_q <= '0;
            end
          end
          S_DONE:  state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign level_data   = data_q;
  assign level_length = len_q;
  assign recording    = rec_q;
  assign done_record  = done_q;
  assign chord_error  = chord_q;

endmodule

// File: tb/tb_note_recorder.sv
// -----------------------------------------------------------------------------
// tb_note_recorder
//
// Directed bench for note_recorder with default parameters (debounce 4,
// idle timeout 64). Inputs change on the falling clock edge; outputs are
// sampled on the falling edge or a few ns after an asynchronous event.
// -----------------------------------------------------------------------------
module tb_note_recorder;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start_record;
  logic [3:0]  note_inputs;
  logic [3:0]  max_length;
  logic [15:0] level_data;
  logic [3:0]  level_length;
  logic        recording;
  logic        done_record;
  logic        chord_error;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Done-pulse monitor: counts done_record cycles and flags any pulse where
  // recording is still high or was not high on the previous sample.
  int   done_cnt  = 0;
  int   shape_bad = 0;
  logic rec_prev  = 1'b0;

  note_recorder #(
    .DEBOUNCE_CYCLES(4),
    .IDLE_TIMEOUT   (64)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .start_record(start_record),
    .note_inputs (note_inputs),
    .max_length  (max_length),
    .level_data  (level_data),
    .level_length(level_length),
    .recording   (recording),
    .done_record (done_record),
    .chord_error (chord_error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done_record) begin
      done_cnt++;
      if (recording || !rec_prev) shape_bad++;
    end
    rec_prev = recording;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic start_rec(input logic [3:0] len);
    @(negedge clk);
    start_record = 1'b1;
    max_length   = len;
    @(negedge clk);
    start_record = 1'b0;
  endtask

  task automatic press(input logic [3:0] key, input int hold, input int rel);
    @(negedge clk);
    note_inputs = key;
    repeat (hold) @(negedge clk);
    note_inputs = 4'd0;
    repeat (rel) @(negedge clk);
  endtask

  task automatic clear_mon();
    done_cnt  = 0;
    shape_bad = 0;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    resetn       = 1'b0;
    start_record = 1'b0;
    note_inputs  = 4'd0;
    max_length   = 4'd0;
    #12;
    vec_cnt++;
    if ({level_data, level_length, recording, done_record, chord_error} !== 23'd0) begin
      err_cnt++;
      $display("FAIL reset_outputs: got data=%h len=%0d rec=%b done=%b chord=%b required all zero",
               level_data, level_length, recording, done_record, chord_error);
    end
    @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    vec_cnt++;
    if (recording !== 1'b0 || done_record !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_idle: got rec=%b done=%b required 0 0", recording, done_record);
    end
  endtask

  task automatic test_clean_four();
    logic [3:0] keys [4];
    keys = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    clear_mon();
    start_rec(4'd4);
    vec_cnt++;
    if (recording !== 1'b1 || level_length !== 4'd0) begin
      err_cnt++;
      $display("FAIL clean_start: got rec=%b len=%0d required 1 0", recording, level_length);
    end
    for (int i = 0; i < 4; i++) press(keys[i], 10, 10);
    vec_cnt++;
    if (level_data !== 16'h1248 || level_length !== 4'd4) begin
      err_cnt++;
      $display("FAIL clean_data: got %h/%0d required 1248/4", level_data, level_length);
    end
    vec_cnt++;
    if (done_cnt !== 1 || shape_bad !== 0 || recording !== 1'b0) begin
      err_cnt++;
      $display("FAIL clean_done: got pulses=%0d badshape=%0d rec=%b required 1 0 0",
               done_cnt, shape_bad, recording);
    end
  endtask

  task automatic test_len_zero();
    logic [3:0] keys [4];
    keys = '{4'b0100, 4'b0001, 4'b0001, 4'b0010};
    clear_mon();
    start_rec(4'd0);
    for (int i = 0; i < 4; i++) press(keys[i], 10, 10);
    vec_cnt++;
    if (level_data !== 16'h4112 || level_length !== 4'd4 || done_cnt !== 1) begin
      err_cnt++;
      $display("FAIL len_zero: got %h/%0d pulses=%0d required 4112/4 1",
               level_data, level_length, done_cnt);
    end
  endtask

  task automatic test_chord();
    logic [3:0] keys [4];
    keys = '{4'b0001, 4'b0011, 4'b1000, 4'b0100};
    clear_mon();
    start_rec(4'd3);
    press(keys[0], 10, 10);
    press(keys[1], 10, 10);
    vec_cnt++;
    if (chord_error !== 1'b1 || level_length !== 4'd1) begin
      err_cnt++;
      $display("FAIL chord_reject: got chord=%b len=%0d required 1 1", chord_error, level_length);
    end
    press(keys[2], 10, 10);
    press(keys[3], 10, 10);
    vec_cnt++;
    if (level_data !== 16'h1840 || level_length !== 4'd3 || chord_error !== 1'b1 || done_cnt !== 1) begin
      err_cnt++;
      $display("FAIL chord_final: got %h/%0d chord=%b pulses=%0d required 1840/3 1 1",
               level_data, level_length, chord_error, done_cnt);
    end
  endtask

  task automatic test_glitch_timeout();
    int waited;
    clear_mon();
    start_rec(4'd4);
    @(negedge clk);
    note_inputs = 4'b0100;
    repeat (2) @(negedge clk);
    note_inputs = 4'd0;
    repeat (12) @(negedge clk);
    vec_cnt++;
    if (level_length !== 4'd0 || recording !== 1'b1 || chord_error !== 1'b0) begin
      err_cnt++;
      $display("FAIL glitch: got len=%0d rec=%b chord=%b required 0 1 0",
               level_length, recording, chord_error);
    end
    // Release at a falling edge; the store lands on the 7th rising edge, the
    // timeout 64 edges later, i.e. 61 samples after the 10-cycle release.
    press(4'b0001, 10, 10);
    waited = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (done_record) begin
        waited = i;
        break;
      end
    end
    vec_cnt++;
    if (waited !== 61) begin
      err_cnt++;
      $display("FAIL timeout_latency: got %0d cycles required 61", waited);
    end
    @(negedge clk);
    vec_cnt++;
    if (level_data !== 16'h1000 || level_length !== 4'd1 || recording !== 1'b0 || done_cnt !== 1) begin
      err_cnt++;
      $display("FAIL timeout_data: got %h/%0d rec=%b pulses=%0d required 1000/1 0 1",
               level_data, level_length, recording, done_cnt);
    end
  endtask

  task automatic test_latency();
    int lat;
    clear_mon();
    start_rec(4'd4);
    @(negedge clk);
    note_inputs = 4'b0010;
    repeat (10) @(negedge clk);
    note_inputs = 4'd0;
    lat = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (level_length !== 4'd0) begin
        lat = i;
        break;
      end
    end
    vec_cnt++;
    if (lat !== 7) begin
      err_cnt++;
      $display("FAIL release_latency: got %0d cycles required 7", lat);
    end
  endtask

  task automatic test_reset_mid();
    clear_mon();
    start_rec(4'd4);
    press(4'b0001, 10, 10);
    press(4'b1000, 10, 10);
    vec_cnt++;
    if (level_length !== 4'd2 || level_data !== 16'h1800) begin
      err_cnt++;
      $display("FAIL mid_pre: got %h/%0d required 1800/2", level_data, level_length);
    end
    #2;
    resetn = 1'b0;
    #1;
    vec_cnt++;
    if ({level_data, level_length, recording, done_record, chord_error} !== 23'd0) begin
      err_cnt++;
      $display("FAIL mid_reset: got data=%h len=%0d rec=%b done=%b chord=%b required all zero",
               level_data, level_length, recording, done_record, chord_error);
    end
    @(negedge clk);
    resetn = 1'b1;
    press(4'b0100, 10, 10);
    vec_cnt++;
    if (level_length !== 4'd0 || recording !== 1'b0 || done_cnt !== 0) begin
      err_cnt++;
      $display("FAIL post_reset_idle: got len=%0d rec=%b pulses=%0d required 0 0 0",
               level_length, recording, done_cnt);
    end
    start_rec(4'd4);
    press(4'b0001, 10, 10);
    start_rec(4'd4);
    vec_cnt++;
    if (level_length !== 4'd0 || level_data !== 16'h0000 || recording !== 1'b1 || done_cnt !== 0) begin
      err_cnt++;
      $display("FAIL restart: got %h/%0d rec=%b pulses=%0d required 0000/0 1 0",
               level_data, level_length, recording, done_cnt);
    end
  endtask

  task automatic test_held_key();
    clear_mon();
    @(negedge clk);
    note_inputs = 4'b0010;
    repeat (10) @(negedge clk);
    start_rec(4'd4);
    repeat (5) @(negedge clk);
    note_inputs = 4'd0;
    repeat (15) @(negedge clk);
    vec_cnt++;
    if (level_length !== 4'd0 || level_data !== 16'h0000) begin
      err_cnt++;
      $display("FAIL held_key: got %h/%0d required 0000/0", level_data, level_length);
    end
    press(4'b1000, 10, 10);
    vec_cnt++;
    if (level_length !== 4'd1 || level_data !== 16'h8000) begin
      err_cnt++;
      $display("FAIL held_next: got %h/%0d required 8000/1", level_data, level_length);
    end
  endtask

  task automatic test_back_to_back();
    // One-note recording with start_record arriving in the DONE cycle.
    clear_mon();
    start_rec(4'd1);
    @(negedge clk);
    note_inputs = 4'b0100;
    repeat (10) @(negedge clk);
    note_inputs = 4'd0;
    repeat (7) @(negedge clk);
    vec_cnt++;
    if (done_record !== 1'b1 || level_data !== 16'h4000) begin
      err_cnt++;
      $display("FAIL b2b_done: got done=%b data=%h required 1 4000", done_record, level_data);
    end
    start_record = 1'b1;
    max_length   = 4'd2;
    @(negedge clk);
    start_record = 1'b0;
    vec_cnt++;
    if (recording !== 1'b1 || level_length !== 4'd0 || level_data !== 16'h0000 ||
        done_record !== 1'b0 || done_cnt !== 1) begin
      err_cnt++;
      $display("FAIL b2b_restart: got rec=%b %h/%0d done=%b pulses=%0d required 1 0000/0 0 1",
               recording, level_data, level_length, done_record, done_cnt);
    end
    press(4'b0001, 10, 10);
    press(4'b0010, 10, 10);
    vec_cnt++;
    if (level_data !== 16'h1200 || level_length !== 4'd2 || done_cnt !== 2) begin
      err_cnt++;
      $display("FAIL b2b_second: got %h/%0d pulses=%0d required 1200/2 2",
               level_data, level_length, done_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_clean_four();
    test_len_zero();
    test_chord();
    test_glitch_timeout();
    test_latency();
    test_reset_mid();
    test_held_key();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
